// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared constants, command and FSM encodings for the rectangle controller
package vga_pkg;

  localparam int H_ACTIVE_DEF = 320;
  localparam int V_ACTIVE_DEF = 480;

  typedef enum logic [1:0] {
    OP_SET_POS  = 2'd0,
    OP_SET_SIZE = 2'd1,
    OP_SET_VEL  = 2'd2,
    OP_RUN      = 2'd3
  } cmd_op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_APPLY  = 3'd1,
    ST_STEP_X = 3'd2,
    ST_STEP_Y = 3'd3,
    ST_COMMIT = 3'd4
  } state_e;

  // Clamp a requested size into [1, lim]
  function automatic logic signed [15:0] clamp_size(input logic signed [15:0] v,
                                                    input logic signed [15:0] lim);
    if (v < 16'sd1) return 16'sd1;
    if (v > lim) return lim;
    return v;
  endfunction

endpackage

// File: rtl/axis_bounce.sv
// rtl/axis_bounce.sv - one-axis position step with bounce off the 0 and limit edges
module axis_bounce (
  input  logic signed [15:0] pos,
  input  logic signed [15:0] vel,
  input  logic signed [15:0] size,
  input  logic signed [15:0] limit,
  output logic signed [15:0] new_pos,
  output logic signed [15:0] new_vel
);

  logic signed [16:0] nx;
  logic signed [17:0] far_edge;
  logic signed [15:0] mag;

  // Step by vel; on crossing an edge pin to that edge and point velocity back inward
  always_comb begin
    nx       = $signed({pos[15], pos}) + $signed({vel[15], vel});
    far_edge = $signed({nx[16], nx}) + $signed({{2{size[15]}}, size});
    mag      = vel[15] ? -vel : vel;
    new_pos  = nx[15:0];
    new_vel  = vel;
    if (nx < 17'sd0) begin
      new_pos = 16'sd0;
      new_vel = mag;
    end else if (far_edge > $signed({{2{limit[15]}}, limit})) begin
      new_pos = limit - size;
      new_vel = -mag;
    end
  end

endmodule

// File: rtl/rect_motion_ctrl.sv
// rtl/rect_motion_ctrl.sv - per-frame rectangle position/size/velocity controller with tear-free bounds
module rect_motion_ctrl
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int DEF_W    = 32,
  parameter int DEF_H    = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vsync,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [15:0] cmd_a,
  input  logic [15:0] cmd_b,
  output logic [15:0] x0,
  output logic [15:0] x1,
  output logic [15:0] y0,
  output logic [15:0] y1,
  output logic        running,
  output logic [15:0] frame_count
);

  localparam logic signed [15:0] H_LIM = 16'(H_ACTIVE);
  localparam logic signed [15:0] V_LIM = 16'(V_ACTIVE);
  localparam logic signed [15:0] W_RST = 16'(DEF_W);
  localparam logic signed [15:0] H_RST = 16'(DEF_H);

  state_e state_q, state_d;
  logic   vs_q;
  logic   running_q, running_d, skip_q, skip_d, sh_run_q, sh_run_d;
  logic [3:0]  pend_q, pend_d;
  logic [15:0] fc_q, fc_d;
  logic signed [15:0] x_q, x_d, y_q, y_d, w_q, w_d, h_q, h_d, vx_q, vx_d, vy_q, vy_d;
  logic signed [15:0] sh_px_q, sh_px_d, sh_py_q, sh_py_d, sh_w_q, sh_w_d, sh_h_q, sh_h_d;
  logic signed [15:0] sh_vx_q, sh_vx_d, sh_vy_q, sh_vy_d;
  logic signed [15:0] x0_q, x0_d, x1_q, x1_d, y0_q, y0_d, y1_q, y1_d;
  logic signed [15:0] bx_pos, bx_vel, by_pos, by_vel;
  logic frame_tick, cmd_fire;

  assign frame_tick  = vs_q & ~vsync;
  assign cmd_ready   = (state_q == ST_IDLE) && !frame_tick;
  assign cmd_fire    = cmd_valid && cmd_ready;
  assign x0          = x0_q;
  assign x1          = x1_q;
  assign y0          = y0_q;
  assign y1          = y1_q;
  assign running     = running_q;
  assign frame_count = fc_q;

  axis_bounce u_bounce_x (.pos(x_q), .vel(vx_q), .size(w_q), .limit(H_LIM),
                          .new_pos(bx_pos), .new_vel(bx_vel));
  axis_bounce u_bounce_y (.pos(y_q), .vel(vy_q), .size(h_q), .limit(V_LIM),
                          .new_pos(by_pos), .new_vel(by_vel));

  // Frame sequencer: shadow commands while idle, then apply, step each axis, commit bounds
  always_comb begin
    state_d = state_q;   running_d = running_q; skip_d = skip_q;   sh_run_d = sh_run_q;
    pend_d  = pend_q;    fc_d = fc_q;
    x_d  = x_q;  y_d  = y_q;  w_d  = w_q;  h_d  = h_q;  vx_d = vx_q; vy_d = vy_q;
    sh_px_d = sh_px_q; sh_py_d = sh_py_q; sh_w_d = sh_w_q; sh_h_d = sh_h_q;
    sh_vx_d = sh_vx_q; sh_vy_d = sh_vy_q;
    x0_d = x0_q; x1_d = x1_q; y0_d = y0_q; y1_d = y1_q;
    case (state_q)
      ST_IDLE: begin
        if (frame_tick) state_d = ST_APPLY;
        if (cmd_fire) begin
          pend_d[cmd_op] = 1'b1;
          case (cmd_op_e'(cmd_op))
            OP_SET_POS:  begin sh_px_d = cmd_a; sh_py_d = cmd_b; end
            OP_SET_SIZE: begin sh_w_d  = cmd_a; sh_h_d  = cmd_b; end
            OP_SET_VEL:  begin sh_vx_d = cmd_a; sh_vy_d = cmd_b; end
            default:     sh_run_d = cmd_a[0];
          endcase
        end
      end
      ST_APPLY: begin
        if (pend_q[OP_SET_SIZE]) begin
          w_d = clamp_size(sh_w_q, H_LIM);
          h_d = clamp_size(sh_h_q, V_LIM);
        end
        if (pend_q[OP_SET_VEL]) begin
          vx_d = sh_vx_q;
          vy_d = sh_vy_q;
        end
        if (pend_q[OP_RUN]) running_d = sh_run_q;
        // A freshly placed rectangle is shown where the host put it, not one step on
        if (pend_q[OP_SET_POS]) begin
          x_d    = sh_px_q;
          y_d    = sh_py_q;
          skip_d = 1'b1;
        end
        pend_d  = 4'b0;
        state_d = ST_STEP_X;
      end
      ST_STEP_X: begin
        if (running_q && !skip_q) begin
          x_d  = bx_pos;
          vx_d = bx_vel;
        end
        state_d = ST_STEP_Y;
      end
      ST_STEP_Y: begin
        if (running_q && !skip_q) begin
          y_d  = by_pos;
          vy_d = by_vel;
        end
        state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        x0_d    = x_q;
        x1_d    = x_q + w_q;
        y0_d    = y_q;
        y1_d    = y_q + h_q;
        fc_d    = fc_q + 16'd1;
        skip_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, shadow and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE; vs_q <= 1'b0; running_q <= 1'b0; skip_q <= 1'b0; sh_run_q <= 1'b0;
      pend_q  <= 4'b0;    fc_q <= 16'd0;
      x_q  <= '0; y_q  <= '0; w_q <= W_RST; h_q <= H_RST; vx_q <= '0; vy_q <= '0;
      sh_px_q <= '0; sh_py_q <= '0; sh_w_q <= '0; sh_h_q <= '0; sh_vx_q <= '0; sh_vy_q <= '0;
      x0_q <= '0; x1_q <= W_RST; y0_q <= '0; y1_q <= H_RST;
    end else begin
      state_q <= state_d; vs_q <= vsync; running_q <= running_d; skip_q <= skip_d;
      sh_run_q <= sh_run_d; pend_q <= pend_d; fc_q <= fc_d;
      x_q  <= x_d;  y_q  <= y_d;  w_q <= w_d; h_q <= h_d; vx_q <= vx_d; vy_q <= vy_d;
      sh_px_q <= sh_px_d; sh_py_q <= sh_py_d; sh_w_q <= sh_w_d; sh_h_q <= sh_h_d;
      sh_vx_q <= sh_vx_d; sh_vy_q <= sh_vy_d;
      x0_q <= x0_d; x1_q <= x1_d; y0_q <= y0_d; y1_q <= y1_d;
    end
  end

endmodule

// File: tb/tb_rect_motion_ctrl.sv
// tb/tb_rect_motion_ctrl.sv - scoreboard bench for rect_motion_ctrl against a frame-level model
module tb_rect_motion_ctrl;

  localparam int HA = 320;
  localparam int VA = 480;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        vsync = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic [15:0] cmd_a = 16'd0;
  logic [15:0] cmd_b = 16'd0;
  logic [15:0] x0, x1, y0, y1, frame_count;
  logic        running;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [15:0] x0, x1, y0, y1, fc;
    logic        run;
    int          commit_edge;
  } exp_t;
  exp_t sb[$];

  // Reference model state
  int mx, my, mw, mh, mvx, mvy, mfc;
  bit mrun;
  bit p_pos, p_size, p_vel, p_run;
  int s_px, s_py, s_w, s_h, s_vx, s_vy;
  bit s_run;

  rect_motion_ctrl dut (
    .clk(clk), .reset(reset), .vsync(vsync),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .x0(x0), .x1(x1), .y0(y0), .y1(y1),
    .running(running), .frame_count(frame_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mx = 0; my = 0; mw = 32; mh = 32; mvx = 0; mvy = 0; mfc = 0; mrun = 0;
    p_pos = 0; p_size = 0; p_vel = 0; p_run = 0;
  endtask

  function automatic int clampi(input int v, input int lim);
    if (v < 1) return 1;
    if (v > lim) return lim;
    return v;
  endfunction

  task automatic step(inout int p, inout int v, input int s, input int lim);
    int n;
    int mag;
    n   = p + v;
    mag = (v < 0) ? -v : v;
    if (n < 0) begin p = 0; v = mag; end
    else if (n + s > lim) begin p = lim - s; v = -mag; end
    else p = n;
  endtask

  task automatic model_accept(input int op, input int a, input int b);
    case (op)
      0: begin s_px = a; s_py = b; p_pos = 1; end
      1: begin s_w = a; s_h = b; p_size = 1; end
      2: begin s_vx = a; s_vy = b; p_vel = 1; end
      default: begin s_run = a[0]; p_run = 1; end
    endcase
  endtask

  task automatic model_frame(input int tick_edge);
    exp_t e;
    bit skip;
    if (p_size) begin mw = clampi(s_w, HA); mh = clampi(s_h, VA); end
    if (p_vel) begin mvx = s_vx; mvy = s_vy; end
    if (p_run) mrun = s_run;
    skip = p_pos;
    if (p_pos) begin mx = s_px; my = s_py; end
    p_pos = 0; p_size = 0; p_vel = 0; p_run = 0;
    if (mrun && !skip) begin
      step(mx, mvx, mw, HA);
      step(my, mvy, mh, VA);
    end
    mfc = (mfc + 1) % 65536;
    e.x0 = 16'(mx); e.x1 = 16'(mx + mw); e.y0 = 16'(my); e.y1 = 16'(my + mh);
    e.fc = 16'(mfc); e.run = mrun; e.commit_edge = tick_edge + 4;
    sb.push_back(e);
  endtask

  task automatic send_cmd(input int op, input int a, input int b);
    int n = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'(op); cmd_a = 16'(a); cmd_b = 16'(b);
    #1;
    while (!cmd_ready && n < 50) begin @(negedge clk); #1; n++; end
    if (!cmd_ready) begin
      check("cmd_accept_timeout", 0, 1);
    end else begin
      @(posedge clk);
      model_accept(op, a, b);
    end
    #1 cmd_valid = 1'b0;
  endtask

  task automatic do_frame();
    @(negedge clk);
    vsync = 1'b0;
    model_frame(cyc + 1);
    repeat (8) @(negedge clk);
    vsync = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Monitor: each frame_count advance is one committed frame; pop and compare it
  logic [15:0] prev_fc;
  always @(negedge clk) begin : mon
    exp_t e;
    #2;
    if (reset) begin
      prev_fc = frame_count;
    end else if (frame_count !== prev_fc) begin
      if (sb.size() == 0) begin
        check("unexpected_commit", int'(frame_count), int'(prev_fc));
      end else begin
        e = sb.pop_front();
        check("sb_x0", int'(x0), int'(e.x0));
        check("sb_x1", int'(x1), int'(e.x1));
        check("sb_y0", int'(y0), int'(e.y0));
        check("sb_y1", int'(y1), int'(e.y1));
        check("sb_running", int'(running), int'(e.run));
        check("sb_frame_count", int'(frame_count), int'(e.fc));
        check("sb_commit_edge", cyc, e.commit_edge);
      end
      prev_fc = frame_count;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin : stim
    int tick_e;
    int acc_e;
    int n;
    int ncmd;
    int op;
    model_reset();
    // 1: reset held 3 cycles
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_x0", int'(x0), 0);
    check("rst_x1", int'(x1), 32);
    check("rst_y0", int'(y0), 0);
    check("rst_y1", int'(y1), 32);
    check("rst_running", int'(running), 0);
    check("rst_cmd_ready", int'(cmd_ready), 1);
    check("rst_frame_count", int'(frame_count), 0);
    repeat (2) @(negedge clk);

    // 2: SET_POS then one frame
    send_cmd(0, 100, 200);
    do_frame();
    check("t2_x0", int'(x0), 100);
    check("t2_x1", int'(x1), 132);
    check("t2_y0", int'(y0), 200);
    check("t2_y1", int'(y1), 232);
    check("t2_fc", int'(frame_count), 1);

    // 3: velocity (5,-3), run, 10 frames
    send_cmd(2, 5, -3);
    send_cmd(3, 1, 0);
    repeat (10) do_frame();
    check("t3_x0", int'(x0), 150);
    check("t3_y0", int'(y0), 170);

    // 4: right and bottom edges, then left and top edges
    send_cmd(0, 285, 445);
    send_cmd(2, 5, 5);
    do_frame();
    do_frame();
    check("t4_right_x0", int'(x0), 288);
    check("t4_right_x1", int'(x1), 320);
    check("t4_bottom_y0", int'(y0), 448);
    check("t4_bottom_y1", int'(y1), 480);
    do_frame();
    check("t4_vx_neg", int'(x0), 283);
    check("t4_vy_neg", int'(y0), 443);
    send_cmd(0, 2, 2);
    send_cmd(2, -5, -5);
    do_frame();
    do_frame();
    check("t4_left_x0", int'(x0), 0);
    check("t4_top_y0", int'(y0), 0);
    do_frame();
    check("t4_vx_pos", int'(x0), 5);
    check("t4_vy_pos", int'(y0), 5);

    // 5: command raised in the tick cycle waits until after COMMIT
    @(negedge clk);
    vsync = 1'b0;
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_a = 16'd10; cmd_b = 16'd20;
    tick_e = cyc + 1;
    model_frame(tick_e);
    #1;
    check("t5_ready_at_tick", int'(cmd_ready), 0);
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); #1; n++; end
    if (!cmd_ready) begin
      check("t5_accept_timeout", 0, 1);
    end else begin
      acc_e = cyc + 1;
      @(posedge clk);
      model_accept(0, 10, 20);
      #1 cmd_valid = 1'b0;
      check("t5_accept_edge", acc_e, tick_e + 5);
    end
    repeat (3) @(negedge clk);
    vsync = 1'b1;
    repeat (2) @(negedge clk);
    do_frame();
    check("t5_applied_x0", int'(x0), 10);
    check("t5_applied_y0", int'(y0), 20);

    // Randomized commands between frames
    for (int f = 0; f < 40; f++) begin
      ncmd = $urandom_range(0, 3);
      for (int c = 0; c < ncmd; c++) begin
        op = $urandom_range(0, 3);
        case (op)
          0: send_cmd(0, int'($urandom_range(0, 400)) - 40, int'($urandom_range(0, 560)) - 40);
          1: send_cmd(1, int'($urandom_range(0, 345)) - 3, int'($urandom_range(0, 505)) - 3);
          2: send_cmd(2, int'($urandom_range(0, 60)) - 30, int'($urandom_range(0, 60)) - 30);
          default: send_cmd(3, (($urandom_range(0, 3) != 0) ? 1 : 0), int'($urandom_range(0, 100)));
        endcase
      end
      do_frame();
    end

    // 6: reset during STEP_X drops the update and the pending SET_SIZE
    send_cmd(1, 100, 100);
    @(negedge clk);
    vsync = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    check("t6_x0", int'(x0), 0);
    check("t6_x1", int'(x1), 32);
    check("t6_y0", int'(y0), 0);
    check("t6_y1", int'(y1), 32);
    check("t6_running", int'(running), 0);
    check("t6_fc", int'(frame_count), 0);
    @(negedge clk);
    reset = 1'b0;
    vsync = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    do_frame();
    check("t6_size_dropped_x1", int'(x1), 32);
    check("t6_size_dropped_y1", int'(y1), 32);

    repeat (4) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
